// File: rtl/npuarc_rtt_prdcr_arb.sv
// Round-robin, message-granular arbiter for the RTT trace output path.
// Requester 0 is the core trace producer and requesters 1..NUM_SWE are the
// software-event producers. A grant is held for a whole message. It ends
// when the last beat is accepted, or when the granted producer stalls for
// TIMEOUT consecutive cycles.
module npuarc_rtt_prdcr_arb #(
    parameter int NUM_SWE = 17,
    parameter int TIMEOUT = 255
) (
    input  logic               rtt_clk,
    input  logic               rst_a,
    input  logic               req_core,
    input  logic [NUM_SWE-1:0] req_swe,
    input  logic [NUM_SWE:0]   vld,
    input  logic [NUM_SWE:0]   last,
    input  logic               out_rdy,
    input  logic               err_clr,
    output logic               out_vld,
    output logic               prdcr_sel_0,
    output logic [NUM_SWE-1:0] swe_prdcr_sel,
    output logic               prdcr_busy,
    output logic               timeout_err
);

    localparam int N  = NUM_SWE + 1;
    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [PW:0]   N_W      = (PW + 1)'(N);
    localparam logic [PW-1:0] LAST_IDX = PW'(N - 1);
    localparam logic [N-1:0]  ONE_N    = N'(1);
    localparam logic [CW-1:0] CNT_MAX  = '1;
    // The release fires on the edge where the counter would reach TIMEOUT,
    // so compare against the value one below it.
    localparam logic [CW-1:0] TO_LAST  = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    typedef enum logic {
        ST_IDLE,
        ST_GRANT
    } state_t;

    state_t        state_reg;
    logic [PW-1:0] ptr_reg;
    logic [PW-1:0] gidx_reg;
    logic [N-1:0]  grant_reg;
    logic          busy_reg;
    logic [CW-1:0] cnt_reg;
    logic          err_reg;

    logic [N-1:0]  req_vec;
    logic          pick_found;
    logic [PW-1:0] pick_idx;
    logic [PW:0]   scan_idx;
    logic [PW-1:0] ptr_next;
    logic          vld_g;
    logic          last_g;
    logic          xfer;
    logic          stall;
    logic          timeout_hit;

    assign req_vec = {req_swe, req_core};

    // Scan requests starting at ptr, wrapping modulo N; the first hit wins.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        scan_idx   = '0;
        for (int k = 0; k < N; k++) begin
            scan_idx = {1'b0, ptr_reg} + (PW + 1)'(k);
            if (scan_idx >= N_W) begin
                scan_idx = scan_idx - N_W;
            end
            if (!pick_found && req_vec[scan_idx[PW-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = scan_idx[PW-1:0];
            end
        end
    end

    // The grant is one-hot, so OR-reducing the masked inputs selects the
    // granted producer's valid and last.
    always_comb begin
        vld_g       = |(grant_reg & vld);
        last_g      = |(grant_reg & last);
        xfer        = vld_g & out_rdy;
        stall       = ~vld_g;
        timeout_hit = (TIMEOUT != 0) && stall && (cnt_reg == TO_LAST);
        ptr_next    = (gidx_reg == LAST_IDX) ? '0 : gidx_reg + PW'(1);
    end

    // Arbitration FSM: one message per grant, with a stall timeout.
    always_ff @(posedge rtt_clk or negedge rst_a) begin
        if (!rst_a) begin
            state_reg <= ST_IDLE;
            ptr_reg   <= '0;
            gidx_reg  <= '0;
            grant_reg <= '0;
            busy_reg  <= 1'b0;
            cnt_reg   <= '0;
            err_reg   <= 1'b0;
        end else begin
            // The clear is applied first so that a same-cycle set below wins.
            if (err_clr) begin
                err_reg <= 1'b0;
            end
            case (state_reg)
                ST_IDLE: begin
                    if (pick_found) begin
                        grant_reg <= ONE_N << pick_idx;
                        gidx_reg  <= pick_idx;
                        busy_reg  <= 1'b1;
                        cnt_reg   <= '0;
                        state_reg <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (xfer && last_g) begin
                        grant_reg <= '0;
                        busy_reg  <= 1'b0;
                        cnt_reg   <= '0;
                        ptr_reg   <= ptr_next;
                        state_reg <= ST_IDLE;
                    end else if (timeout_hit) begin
                        grant_reg <= '0;
                        busy_reg  <= 1'b0;
                        cnt_reg   <= '0;
                        err_reg   <= 1'b1;
                        ptr_reg   <= ptr_next;
                        state_reg <= ST_IDLE;
                    end else if (xfer) begin
                        cnt_reg <= '0;
                    end else if (stall && (cnt_reg != CNT_MAX)) begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // Map the grant vector onto the per-SWE select outputs.
    generate
        for (genvar gi = 0; gi < NUM_SWE; gi++) begin : g_swe_sel
            assign swe_prdcr_sel[gi] = grant_reg[gi+1];
        end
    endgenerate

    assign prdcr_sel_0 = grant_reg[0];
    assign prdcr_busy  = busy_reg;
    assign timeout_err = err_reg;
    assign out_vld     = vld_g;

endmodule
